// File: rtl/relu_maxpool_float16.sv
// rtl/relu_maxpool_float16.sv - optional ReLU followed by windowed float16 max-pool
module relu_maxpool_float16 #(
    parameter int DATA_WIDTH    = 16,
    parameter int CLK_NUM_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [CLK_NUM_WIDTH-1:0] pool_num,
    input  logic                     relu_en,
    input  logic                     flush,
    output logic                     pool_ready,
    output logic [DATA_WIDTH-1:0]    pool_result,
    output logic                     window_busy
);

    logic [CLK_NUM_WIDTH-1:0] count;
    logic [CLK_NUM_WIDTH-1:0] size_reg;
    logic [DATA_WIDTH-1:0]    max_reg;

    logic [DATA_WIDTH-1:0]    x;
    logic [DATA_WIDTH-1:0]    cand;
    logic [CLK_NUM_WIDTH-1:0] eff_size;
    logic [CLK_NUM_WIDTH-1:0] next_count;
    logic                     close_on_sample;
    logic                     close_on_flush;

    // Monotonic unsigned key: positives above negatives, negatives reversed.
    // -0 maps below +0 on purpose; NaN/Inf simply sort by their bits.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? ~v : {1'b1, v[DATA_WIDTH-2:0]};
    endfunction

    // ReLU, running-max candidate and window-close decisions for this cycle
    always_comb begin
        x          = (relu_en && data_in[DATA_WIDTH-1]) ? '0 : data_in;
        next_count = count + CLK_NUM_WIDTH'(1);
        cand       = x;
        eff_size   = size_reg;
        if (count == '0) begin
            // pool_num is only looked at when a window opens; 0 means 1
            eff_size = (pool_num == '0) ? CLK_NUM_WIDTH'(1) : pool_num;
        end else if (order_key(x) <= order_key(max_reg)) begin
            // ties keep the stored value
            cand = max_reg;
        end
        close_on_sample = data_valid && ((next_count == eff_size) || flush);
        close_on_flush  = !data_valid && flush && (count != '0);
    end

    assign window_busy = (count != '0);

    // Window state and the one-cycle result pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_ready  <= 1'b0;
            pool_result <= '0;
            count       <= '0;
            size_reg    <= '0;
            max_reg     <= '0;
        end else begin
            pool_ready <= 1'b0;
            if (data_valid) begin
                if (count == '0) begin
                    size_reg <= eff_size;
                end
                max_reg <= cand;
                if (close_on_sample) begin
                    pool_ready  <= 1'b1;
                    pool_result <= cand;
                    count       <= '0;
                end else begin
                    count <= next_count;
                end
            end else if (close_on_flush) begin
                pool_ready  <= 1'b1;
                pool_result <= max_reg;
                count       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_float16.sv
// tb/tb_relu_maxpool_float16.sv - randomized and directed bench for relu_maxpool_float16
module tb_relu_maxpool_float16;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic [15:0] data_in;
    logic [7:0]  pool_num;
    logic        relu_en;
    logic        flush;
    logic        pool_ready;
    logic [15:0] pool_result;
    logic        window_busy;

    int n_checks;
    int n_pass;

    logic [15:0] win[$];
    int          win_size;
    logic [15:0] exp_result;

    relu_maxpool_float16 #(.DATA_WIDTH(16), .CLK_NUM_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .pool_num    (pool_num),
        .relu_en     (relu_en),
        .flush       (flush),
        .pool_ready  (pool_ready),
        .pool_result (pool_result),
        .window_busy (window_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // a strictly greater than b as half-precision values, -0 below +0
    function automatic bit f16_gt(input logic [15:0] a, input logic [15:0] b);
        if (a[15] != b[15]) return b[15];
        if (!a[15]) return a[14:0] > b[14:0];
        return a[14:0] < b[14:0];
    endfunction

    function automatic logic [15:0] window_max();
        logic [15:0] m;
        m = win[0];
        foreach (win[i]) if (f16_gt(win[i], m)) m = win[i];
        return m;
    endfunction

    // One clock: drive at negedge, predict, check 1 time unit after posedge
    task automatic cycle(input bit dv, input logic [15:0] d, input bit fl);
        bit          exp_ready;
        logic [15:0] x;
        data_valid = dv;
        data_in    = d;
        flush      = fl;
        exp_ready  = 1'b0;
        if (dv) begin
            x = (relu_en && d[15]) ? 16'h0000 : d;
            if (win.size() == 0) win_size = (pool_num == 0) ? 1 : int'(pool_num);
            win.push_back(x);
            if (win.size() == win_size || fl) begin
                exp_ready  = 1'b1;
                exp_result = window_max();
                win.delete();
            end
        end else if (fl && win.size() > 0) begin
            exp_ready  = 1'b1;
            exp_result = window_max();
            win.delete();
        end
        @(posedge clk);
        #1;
        check("pool_ready", {15'b0, pool_ready}, {15'b0, exp_ready});
        check("pool_result", pool_result, exp_result);
        check("window_busy", {15'b0, window_busy}, {15'b0, win.size() != 0});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_ready", {15'b0, pool_ready}, 16'h0);
        check("rst_result", pool_result, 16'h0000);
        check("rst_busy", {15'b0, window_busy}, 16'h0);
        win.delete();
        exp_result = 16'h0000;
        data_valid = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        win_size   = 1;
        exp_result = 16'h0000;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 16'h0000;
        pool_num   = 8'd4;
        relu_en    = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        do_reset();

        // basic 4-sample window
        relu_en = 1'b0; pool_num = 8'd4;
        cycle(1, 16'h4000, 0); cycle(1, 16'h4400, 0); cycle(1, 16'h4600, 0); cycle(1, 16'h4000, 0);
        check("dir_max4", pool_result, 16'h4600);
        cycle(0, 0, 0);

        // ReLU on / off over negatives
        relu_en = 1'b1; pool_num = 8'd2;
        cycle(1, 16'hC000, 0); cycle(1, 16'hBC00, 0);
        check("dir_relu_on", pool_result, 16'h0000);
        relu_en = 1'b0;
        cycle(1, 16'hC000, 0); cycle(1, 16'hBC00, 0);
        check("dir_relu_off", pool_result, 16'hBC00);
        cycle(0, 0, 0);

        // size-1 streaming
        pool_num = 8'd1;
        cycle(1, 16'h3C00, 0); cycle(1, 16'h4000, 0); cycle(1, 16'hC000, 0);
        cycle(0, 0, 0);

        // signed zeros, then pool_num change mid-window
        pool_num = 8'd3;
        cycle(1, 16'h8000, 0); cycle(1, 16'h0000, 0); cycle(1, 16'h8000, 0);
        check("dir_zero", pool_result, 16'h0000);
        cycle(1, 16'h4000, 0);
        pool_num = 8'd2;
        cycle(1, 16'h4200, 0); cycle(1, 16'h3C00, 0);
        check("dir_latch", pool_result, 16'h4200);
        cycle(0, 0, 0);

        // flush variants
        pool_num = 8'd4;
        cycle(1, 16'h4000, 0); cycle(1, 16'h4400, 0); cycle(0, 0, 1);
        check("dir_flush", pool_result, 16'h4400);
        cycle(0, 0, 1);
        cycle(1, 16'h4000, 0); cycle(1, 16'h4600, 1);
        check("dir_flush_dv", pool_result, 16'h4600);
        cycle(0, 0, 0);

        // reset mid-window
        cycle(1, 16'h4800, 0); cycle(1, 16'h4A00, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 16'h3C00, 0);
        check("dir_post_rst", pool_result, 16'h3C00);
        cycle(0, 0, 0); cycle(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) pool_num = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) relu_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_float16.md
Name: relu_maxpool_float16

Overview:
- Downstream consumer of the float16 multiply-add unit in the conv datapath.
- Takes each finished convolution result (its result_ready / mult_add_result pair), applies optional ReLU, and max-pools over a programmable number of consecutive results.
- Emits one float16 pooled value per window as a single-cycle valid pulse, feeding the feature-map write-back stage.

Parameters:
- DATA_WIDTH, 16, float16 word width (fixed half-precision format: 1 sign, 5 exponent, 10 mantissa).
- CLK_NUM_WIDTH, 8, width of the pool-size field (matches the clk_num field of the multiply-add unit).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0: reset; 1: none).
- data_valid  input  1  driven by upstream result_ready; every cycle it is high is one sample.
- data_in  input  DATA_WIDTH  upstream mult_add_result, sampled when data_valid=1.
- pool_num  input  CLK_NUM_WIDTH  samples per pooling window; 0 is treated as 1.
- relu_en  input  1  1: apply ReLU before pooling; 0: bypass.
- flush  input  1  single-cycle request to close the current partial window.
- pool_ready  output  1  one-cycle pulse; pool_result is valid while it is high.
- pool_result  output  DATA_WIDTH  pooled float16 value; holds its last value between pulses.
- window_busy  output  1  1 while a window has at least one accepted sample.

Behaviour:
- Reset (rst=0, asynchronous): pool_ready=0, pool_result=16'h0000, window_busy=0, sample counter=0, max register=0, latched size=0. Asserting reset mid-window discards the partial window; no output is produced for it.
- ReLU stage (combinational on data_in): if relu_en=1 and sign bit=1 (including -0, 16'h8000), x=16'h0000; otherwise x=data_in.
- Float16 ordering uses a 16-bit unsigned key: sign=0 gives key={1'b1, bits[14:0]}; sign=1 gives key=~bits.
  - Larger key wins.
  - On equal keys the stored value is kept.
  - +0 and -0 are unequal under this key (+0 > -0), which is intended.
  - NaN/Inf are ordered by bit pattern with no special handling.
- Window start (data_valid=1, counter=0):
  - Latch size=max(pool_num,1).
  - max_reg<=x, counter<=1, window_busy<=1.
  - pool_num changes mid-window are ignored until the next window starts.
- Continuing window (data_valid=1, counter>0): max_reg<=larger(max_reg,x), counter<=counter+1.
- Window close happens when an accepted sample makes the count equal size, including size=1 on the first sample:
  - Next cycle: pool_ready=1 and pool_result=larger(max_reg,x), or x for size 1.
  - Same edge: counter<=0, window_busy<=0.
  - Latency is exactly 1 cycle from the last sample edge to pool_ready.
- Back-to-back windows: a sample arriving the cycle after a close starts a new window with no bubble. Continuous data_valid=1 is sustained at full rate.
- flush=1:
  - Counter>0 and data_valid=0: close with pool_result=max_reg.
  - data_valid=1 in the same cycle: the sample is included first, then the window closes.
  - Counter=0 and data_valid=0: ignored, no pulse.
  - data_valid=1 with counter=0 and flush=1: a one-sample window, outputting x.
- pool_ready is never high for two consecutive cycles unless two windows close on consecutive cycles (e.g. size=1 streaming).
- Counter width is CLK_NUM_WIDTH. It never wraps because it resets at size ≤ 255.

Test Plan:
- relu_en=0, pool_num=4, samples 4000, 4400, 4600, 4000 on consecutive cycles -> single pool_ready pulse 1 cycle after the 4th sample, pool_result=16'h4600.
- relu_en=1, pool_num=2, samples C000 (-2), BC00 (-1) -> pool_result=16'h0000. Repeat with relu_en=0 -> pool_result=16'hBC00.
- pool_num=1, continuous data_valid with 3C00, 4000, C000, relu_en=0 -> pool_ready high 3 consecutive cycles with 3C00, 4000, C000.
- relu_en=0, pool_num=3 -> first window 8000 (-0), 0000 (+0), 8000 gives 16'h0000. Then set pool_num=2 mid-window of a second window 4000, 4200, 3C00 -> that window uses size 3, result 4200.
- pool_num=4, samples 4000, 4400, then flush alone -> pool_result=4400. Flush with window_busy=0 -> no pulse. Flush coincident with a 4600 sample after 4000 -> 4600.
- pool_num=4, two samples, then rst=0 for one cycle, then four samples 3C00 each -> one pulse only, pool_result=3C00; all outputs read 0 during reset.
